ldm_stm_seq: RTL and testbench

Parametrised load/store-multiple sequencer for the ARMv4 core. It accepts a decoded LDM/STM (P, U, S, L, register list) and expands it into a stream of per-register memory beats, each carrying a register code and a byte offset from the base register. It issues up to LANES registers per cycle and reports the base writeback offset. The execute stage is held until the last beat, and a flush is requested when PC is loaded.

---
 rtl/ldm_pkg.sv | 23 ++
 rtl/ldm_stm_seq_lsb_pick.sv | 23 ++
 rtl/ldm_stm_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_pkg.sv
// Shared encodings for the LDM/STM sequencer: addressing modes from {P,U},
// sequencer states and the default register stride.
package ldm_pkg;

  localparam int WORD_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    AM_DA = 2'b00,
    AM_IA = 2'b01,
    AM_DB = 2'b10,
    AM_IB = 2'b11
  } amode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  function automatic amode_e amode_of(input logic p, input logic u);
    return amode_e'({p, u});
  endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_pick.sv
// Lowest-set-bit finder: reports whether any bit is set, its index and a
// one-hot mask of it, so the caller can clear it and chain the next pick.
module lsb_pick #(
  parameter int W  = 16,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic          found_o,
  output logic [IW-1:0] index_o,
  output logic [W-1:0]  onehot_o
);

  // Isolate the lowest set bit and encode its position
  always_comb begin
    found_o  = |vec_i;
    onehot_o = vec_i & (~vec_i + W'(1'b1));
    index_o  = '0;
    for (int i = 0; i < W; i++) begin
      index_o = index_o | (onehot_o[i] ? IW'(i) : IW'(1'b0));
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: expands a decoded register list into registered memory
// beats of up to LANES registers, with offsets relative to the base register.
module ldm_stm_seq
  import ldm_pkg::*;
#(
  parameter int REGLIST_W  = 16,
  parameter int LANES      = 1,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int PC_IDX     = 15,
  localparam int RC_W      = $clog2(REGLIST_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    i_vld,
  input  logic                    i_p,
  input  logic                    i_u,
  input  logic                    i_s,
  input  logic                    i_l,
  input  logic [REGLIST_W-1:0]    i_reglist,
  output logic                    o_hold,
  output logic                    o_mem_vld,
  output logic [LANES-1:0]        o_lane_vld,
  output logic [LANES*RC_W-1:0]   o_reg_code,
  output logic [LANES*ADDR_W-1:0] o_offset,
  output logic [ADDR_W-1:0]       o_wb_offset,
  output logic                    o_last,
  output logic                    o_spsr_res,
  output logic                    o_user_bank,
  output logic                    o_flushreq
);

  localparam int KW = $clog2(REGLIST_W + 1);
  localparam logic [ADDR_W-1:0] WB = ADDR_W'(WORD_BYTES);

  state_e                    state_q, state_d;
  logic [REGLIST_W-1:0]      rem_q, rem_d;
  logic [KW-1:0]             k_q, k_d;
  logic [ADDR_W-1:0]         start_q, start_d;
  logic                      s_q, s_d, l_q, l_d, pcl_q, pcl_d;
  logic                      mem_vld_q, mem_vld_d, last_q, last_d;
  logic                      spsr_q, spsr_d, ubank_q, ubank_d, flush_q, flush_d;
  logic [LANES-1:0]          lane_vld_q, lane_vld_d;
  logic [LANES*RC_W-1:0]     code_q, code_d;
  logic [LANES*ADDR_W-1:0]   off_q, off_d;
  logic [ADDR_W-1:0]         wb_q, wb_d;

  logic                      accept_s, load_s;
  logic [KW-1:0]             cnt_s, src_k_s, n_issued_s;
  logic [ADDR_W-1:0]         n_bytes_s, start_calc_s, wb_calc_s, src_start_s;
  logic [REGLIST_W-1:0]      src_list_s, rem_next_s;
  logic                      src_s_s, src_l_s, src_pcl_s, pc_beat_s;
  logic [LANES-1:0]          found_s;
  logic [LANES-1:0][RC_W-1:0] idx_s;
  logic [LANES*RC_W-1:0]     beat_code_s;
  logic [LANES*ADDR_W-1:0]   beat_off_s;

  // A new instruction may enter while idle or alongside the final beat
  assign accept_s = i_vld & en & ((state_q == ST_IDLE) | last_q);
  assign load_s   = accept_s | (en & (state_q == ST_XFER) & ~last_q);

  // Population count of the incoming register list
  always_comb begin
    cnt_s = '0;
    for (int b = 0; b < REGLIST_W; b++) begin
      cnt_s = cnt_s + KW'(i_reglist[b]);
    end
  end

  assign n_bytes_s = ADDR_W'(cnt_s) * WB;
  assign wb_calc_s = i_u ? n_bytes_s : (ADDR_W'(1'b0) - n_bytes_s);

  // Offset of the lowest-addressed register for each addressing mode
  always_comb begin
    case (amode_of(i_p, i_u))
      AM_IA:   start_calc_s = '0;
      AM_IB:   start_calc_s = WB;
      AM_DA:   start_calc_s = WB - n_bytes_s;
      AM_DB:   start_calc_s = ADDR_W'(1'b0) - n_bytes_s;
      default: start_calc_s = '0;
    endcase
  end

  assign src_list_s  = accept_s ? i_reglist : rem_q;
  assign src_k_s     = accept_s ? KW'(1'b0) : k_q;
  assign src_start_s = accept_s ? start_calc_s : start_q;
  assign src_s_s     = accept_s ? i_s : s_q;
  assign src_l_s     = accept_s ? i_l : l_q;
  assign src_pcl_s   = accept_s ? i_reglist[PC_IDX] : pcl_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [REGLIST_W-1:0] vec_s, oh_s, nxt_s;
    if (g == 0) begin : g_first
      assign vec_s = src_list_s;
    end else begin : g_chain
      assign vec_s = g_lane[g-1].nxt_s;
    end
    lsb_pick #(.W(REGLIST_W), .IW(RC_W)) u_pick (
      .vec_i    (vec_s),
      .found_o  (found_s[g]),
      .index_o  (idx_s[g]),
      .onehot_o (oh_s)
    );
    assign nxt_s = vec_s & ~oh_s;
  end

  assign rem_next_s = g_lane[LANES-1].nxt_s;

  // Per-lane register code and offset of the beat being formed
  always_comb begin
    beat_code_s = '0;
    beat_off_s  = '0;
    pc_beat_s   = 1'b0;
    n_issued_s  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (found_s[j]) begin
        beat_code_s[j*RC_W +: RC_W]     = idx_s[j];
        beat_off_s[j*ADDR_W +: ADDR_W]  = src_start_s + (ADDR_W'(src_k_s) + ADDR_W'(j)) * WB;
        pc_beat_s                       = pc_beat_s | (idx_s[j] == RC_W'(PC_IDX));
        n_issued_s                      = n_issued_s + KW'(1'b1);
      end else begin
        beat_code_s[j*RC_W +: RC_W]     = '0;
        beat_off_s[j*ADDR_W +: ADDR_W]  = '0;
      end
    end
  end

  // Next-state and next-output selection
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    k_d        = k_q;
    start_d    = start_q;
    s_d        = s_q;
    l_d        = l_q;
    pcl_d      = pcl_q;
    wb_d       = wb_q;
    mem_vld_d  = mem_vld_q;
    lane_vld_d = lane_vld_q;
    code_d     = code_q;
    off_d      = off_q;
    last_d     = last_q;
    spsr_d     = spsr_q;
    ubank_d    = ubank_q;
    flush_d    = flush_q;
    if (load_s) begin
      state_d    = ST_XFER;
      rem_d      = rem_next_s;
      k_d        = src_k_s + n_issued_s;
      start_d    = src_start_s;
      s_d        = src_s_s;
      l_d        = src_l_s;
      pcl_d      = src_pcl_s;
      wb_d       = accept_s ? wb_calc_s : wb_q;
      mem_vld_d  = found_s[0];
      lane_vld_d = found_s;
      code_d     = beat_code_s;
      off_d      = beat_off_s;
      last_d     = (rem_next_s == '0);
      spsr_d     = src_s_s & src_l_s & pc_beat_s;
      ubank_d    = src_s_s & ~(src_l_s & src_pcl_s) & found_s[0];
      flush_d    = src_l_s & pc_beat_s;
    end else if (en && state_q == ST_XFER) begin
      // Final beat shown with nothing queued behind it: drop back to idle
      state_d    = ST_IDLE;
      rem_d      = '0;
      k_d        = '0;
      mem_vld_d  = 1'b0;
      lane_vld_d = '0;
      code_d     = '0;
      off_d      = '0;
      last_d     = 1'b0;
      spsr_d     = 1'b0;
      ubank_d    = 1'b0;
      flush_d    = 1'b0;
    end else begin
      state_d    = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      k_q        <= '0;
      start_q    <= '0;
      s_q        <= 1'b0;
      l_q        <= 1'b0;
      pcl_q      <= 1'b0;
      wb_q       <= '0;
      mem_vld_q  <= 1'b0;
      lane_vld_q <= '0;
      code_q     <= '0;
      off_q      <= '0;
      last_q     <= 1'b0;
      spsr_q     <= 1'b0;
      ubank_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      k_q        <= k_d;
      start_q    <= start_d;
      s_q        <= s_d;
      l_q        <= l_d;
      pcl_q      <= pcl_d;
      wb_q       <= wb_d;
      mem_vld_q  <= mem_vld_d;
      lane_vld_q <= lane_vld_d;
      code_q     <= code_d;
      off_q      <= off_d;
      last_q     <= last_d;
      spsr_q     <= spsr_d;
      ubank_q    <= ubank_d;
      flush_q    <= flush_d;
    end
  end

  assign o_hold      = (state_q == ST_XFER) & ~last_q;
  assign o_mem_vld   = mem_vld_q;
  assign o_lane_vld  = lane_vld_q;
  assign o_reg_code  = code_q;
  assign o_offset    = off_q;
  assign o_wb_offset = wb_q;
  assign o_last      = last_q;
  assign o_spsr_res  = spsr_q;
  assign o_user_bank = ubank_q;
  assign o_flushreq  = flush_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: one LANES=1 and one LANES=2 instance,
// table-driven cycle vectors plus hand-written long-list and async-reset runs.
module tb_ldm_stm_seq;

  typedef struct packed {
    logic        hold;
    logic        mem_vld;
    logic [1:0]  lane_vld;
    logic [3:0]  rc1;
    logic [3:0]  rc0;
    logic [31:0] off1;
    logic [31:0] off0;
    logic        last;
    logic        spsr;
    logic        ubank;
    logic        flush;
    logic [31:0] wb;
  } obs_t;

  typedef struct {
    logic        sel;
    logic        rst;
    logic        en;
    logic        vld;
    logic        p, u, s, l;
    logic [15:0] list;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, en, vld1, vld2, p_r, u_r, s_r, l_r;
  logic [15:0] list_r;

  logic        h1, m1, la1, sp1, ub1, fl1;
  logic [0:0]  lv1;
  logic [3:0]  rc1_w;
  logic [31:0] of1, wb1;
  logic        h2, m2, la2, sp2, ub2, fl2;
  logic [1:0]  lv2;
  logic [7:0]  rc2_w;
  logic [63:0] of2;
  logic [31:0] wb2;

  int n_chk = 0;
  int n_pass = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  ldm_stm_seq #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .i_vld(vld1), .i_p(p_r), .i_u(u_r),
    .i_s(s_r), .i_l(l_r), .i_reglist(list_r), .o_hold(h1), .o_mem_vld(m1),
    .o_lane_vld(lv1), .o_reg_code(rc1_w), .o_offset(of1), .o_wb_offset(wb1),
    .o_last(la1), .o_spsr_res(sp1), .o_user_bank(ub1), .o_flushreq(fl1)
  );

  ldm_stm_seq #(.LANES(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .i_vld(vld2), .i_p(p_r), .i_u(u_r),
    .i_s(s_r), .i_l(l_r), .i_reglist(list_r), .o_hold(h2), .o_mem_vld(m2),
    .o_lane_vld(lv2), .o_reg_code(rc2_w), .o_offset(of2), .o_wb_offset(wb2),
    .o_last(la2), .o_spsr_res(sp2), .o_user_bank(ub2), .o_flushreq(fl2)
  );

  function automatic obs_t ob(bit hold, bit mv, bit [1:0] lv, int rc0, int off0,
                              int rc1, int off1, bit last, bit sp, bit ub, bit fl, int wb);
    obs_t o;
    o.hold = hold; o.mem_vld = mv; o.lane_vld = lv;
    o.rc0 = 4'(rc0); o.off0 = 32'(off0); o.rc1 = 4'(rc1); o.off1 = 32'(off1);
    o.last = last; o.spsr = sp; o.ubank = ub; o.flush = fl; o.wb = 32'(wb);
    return o;
  endfunction

  function automatic obs_t b1(bit hold, int rc, int off, bit last, bit sp, bit ub, bit fl, int wb);
    return ob(hold, 1'b1, 2'b01, rc, off, 0, 0, last, sp, ub, fl, wb);
  endfunction

  function automatic obs_t idle(int wb);
    return ob(1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, wb);
  endfunction

  function automatic obs_t get_obs(bit sel);
    obs_t o;
    if (sel) begin
      o = '{hold: h2, mem_vld: m2, lane_vld: lv2, rc1: rc2_w[7:4], rc0: rc2_w[3:0],
            off1: of2[63:32], off0: of2[31:0], last: la2, spsr: sp2, ubank: ub2,
            flush: fl2, wb: wb2};
    end else begin
      o = '{hold: h1, mem_vld: m1, lane_vld: {1'b0, lv1}, rc1: 4'd0, rc0: rc1_w,
            off1: 32'd0, off0: of1, last: la1, spsr: sp1, ubank: ub1,
            flush: fl1, wb: wb1};
    end
    return o;
  endfunction

  task automatic chk(input string nm, input int idx, input obs_t act, input obs_t ex);
    n_chk++;
    if (act === ex) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, ex);
  endtask

  task automatic add(input bit sel, input bit r, input bit e, input bit v, input bit p,
                     input bit u, input bit s, input bit l, input logic [15:0] lst, input obs_t ex);
    vec_t t;
    t.sel = sel; t.rst = r; t.en = e; t.vld = v; t.p = p; t.u = u; t.s = s; t.l = l;
    t.list = lst; t.exp = ex;
    vq.push_back(t);
  endtask

  initial begin
    obs_t got;
    int beats;
    bit done;

    rst = 1'b1; en = 1'b1; vld1 = 1'b0; vld2 = 1'b0;
    p_r = 1'b0; u_r = 1'b0; s_r = 1'b0; l_r = 1'b0; list_r = 16'h0000;

    // sel rst en vld p u s l list  expected
    // IA STM r0-r2; a second i_vld during hold is ignored
    add(0,0,1,1, 0,1,0,0, 16'h0007, b1(1, 0, 0, 0,0,0,0, 12));
    add(0,0,1,1, 1,0,1,1, 16'h00FF, b1(1, 1, 4, 0,0,0,0, 12));
    add(0,0,1,0, 0,0,0,0, 16'h0000, b1(0, 2, 8, 1,0,0,0, 12));
    add(0,0,1,0, 0,0,0,0, 16'h0000, idle(12));
    // DB LDM^ r0,pc
    add(0,0,1,1, 1,0,1,1, 16'h8001, b1(1, 0, -8, 0,0,0,0, -8));
    add(0,0,1,0, 0,0,0,0, 16'h0000, b1(0, 15, -4, 1,1,0,1, -8));
    add(0,0,1,0, 0,0,0,0, 16'h0000, idle(-8));
    // IA STM^ r1,pc: user bank on every beat, no flush
    add(0,0,1,1, 0,1,1,0, 16'h8002, b1(1, 1, 0, 0,0,1,0, 8));
    add(0,0,1,0, 0,0,0,0, 16'h0000, b1(0, 15, 4, 1,0,1,0, 8));
    add(0,0,1,0, 0,0,0,0, 16'h0000, idle(8));
    // DA LDM r1,r2 then back-to-back IA LDM r0 on the final beat
    add(0,0,1,1, 0,0,0,1, 16'h0006, b1(1, 1, -4, 0,0,0,0, -8));
    add(0,0,1,0, 0,0,0,0, 16'h0000, b1(0, 2, 0, 1,0,0,0, -8));
    add(0,0,1,1, 0,1,0,1, 16'h0001, b1(0, 0, 0, 1,0,0,0, 4));
    add(0,0,1,0, 0,0,0,0, 16'h0000, idle(4));
    // empty list
    add(0,0,1,1, 0,1,0,0, 16'h0000, ob(0,0,2'b00,0,0,0,0,1,0,0,0,0));
    add(0,0,1,0, 0,0,0,0, 16'h0000, idle(0));
    // en low for three cycles mid-transfer
    add(0,0,1,1, 0,1,0,1, 16'h0007, b1(1, 0, 0, 0,0,0,0, 12));
    add(0,0,0,0, 0,1,0,1, 16'h0000, b1(1, 0, 0, 0,0,0,0, 12));
    add(0,0,0,1, 0,1,0,1, 16'h0003, b1(1, 0, 0, 0,0,0,0, 12));
    add(0,0,0,0, 0,1,0,1, 16'h0000, b1(1, 0, 0, 0,0,0,0, 12));
    add(0,0,1,0, 0,1,0,1, 16'h0000, b1(1, 1, 4, 0,0,0,0, 12));
    add(0,0,1,0, 0,1,0,1, 16'h0000, b1(0, 2, 8, 1,0,0,0, 12));
    add(0,0,1,0, 0,1,0,1, 16'h0000, idle(12));
    add(0,0,0,1, 0,1,0,0, 16'h0003, idle(12));
    add(0,0,1,0, 0,1,0,0, 16'h0003, idle(12));
    // synchronous-looking rst pulse mid-transfer, then a normal accept
    add(0,0,1,1, 0,1,0,0, 16'h000F, b1(1, 0, 0, 0,0,0,0, 16));
    add(0,1,1,0, 0,1,0,0, 16'h0000, idle(0));
    add(0,0,1,1, 0,1,0,0, 16'h0003, b1(1, 0, 0, 0,0,0,0, 8));
    add(0,0,1,0, 0,1,0,0, 16'h0000, b1(0, 1, 4, 1,0,0,0, 8));
    add(0,0,1,0, 0,1,0,0, 16'h0000, idle(8));
    // LANES=2: IB r4-r7
    add(1,0,1,1, 1,1,0,0, 16'h00F0, ob(1,1,2'b11, 4,4, 5,8, 0,0,0,0, 16));
    add(1,0,1,0, 0,0,0,0, 16'h0000, ob(0,1,2'b11, 6,12, 7,16, 1,0,0,0, 16));
    add(1,0,1,0, 0,0,0,0, 16'h0000, idle(16));
    // LANES=2: odd list IA r0,r4,r8
    add(1,0,1,1, 0,1,0,0, 16'h0111, ob(1,1,2'b11, 0,0, 4,4, 0,0,0,0, 12));
    add(1,0,1,0, 0,0,0,0, 16'h0000, ob(0,1,2'b01, 8,8, 0,0, 1,0,0,0, 12));
    add(1,0,1,0, 0,0,0,0, 16'h0000, idle(12));
    // LANES=2: DB LDM^ r14,pc in a single final beat
    add(1,0,1,1, 1,0,1,1, 16'hC000, ob(0,1,2'b11, 14,-8, 15,-4, 1,1,0,1, -8));
    add(1,0,1,0, 0,0,0,0, 16'h0000, idle(-8));
    // LANES=2: DA r0-r2 then back-to-back IA r0,r1
    add(1,0,1,1, 0,0,0,0, 16'h0007, ob(1,1,2'b11, 0,-8, 1,-4, 0,0,0,0, -12));
    add(1,0,1,0, 0,0,0,0, 16'h0000, ob(0,1,2'b01, 2,0, 0,0, 1,0,0,0, -12));
    add(1,0,1,1, 0,1,0,0, 16'h0003, ob(0,1,2'b11, 0,0, 1,4, 1,0,0,0, 8));
    add(1,0,1,0, 0,0,0,0, 16'h0000, idle(8));
    // LANES=2: empty DB list
    add(1,0,1,1, 1,0,0,0, 16'h0000, ob(0,0,2'b00,0,0,0,0,1,0,0,0,0));
    add(1,0,1,0, 0,0,0,0, 16'h0000, idle(0));

    // reset state
    @(posedge clk); #1;
    chk("reset_l1", 0, get_obs(0), idle(0));
    chk("reset_l2", 0, get_obs(1), idle(0));
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; en = vq[i].en;
      vld1 = vq[i].vld & ~vq[i].sel; vld2 = vq[i].vld & vq[i].sel;
      p_r = vq[i].p; u_r = vq[i].u; s_r = vq[i].s; l_r = vq[i].l; list_r = vq[i].list;
      @(posedge clk); #1;
      chk("vec", i, get_obs(vq[i].sel), vq[i].exp);
    end
    rst = 1'b0; en = 1'b1; vld1 = 1'b0; vld2 = 1'b0;

    // full list DB LDM on LANES=1, bounded wait for o_last
    p_r = 1'b1; u_r = 1'b0; s_r = 1'b0; l_r = 1'b1; list_r = 16'hFFFF; vld1 = 1'b1;
    @(posedge clk); #1;
    vld1 = 1'b0;
    beats = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      got = get_obs(0);
      chk("full_beat", beats, got,
          b1(beats != 15, beats, -64 + 4*beats, beats == 15, 0, 0, beats == 15, -64));
      beats++;
      if (got.last) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_chk++;
    if (done && beats == 16) n_pass++;
    else $display("FAIL full_count: got %0d beats done=%0d expected 16 beats", beats, done);
    @(posedge clk); #1;
    chk("full_idle", 0, get_obs(0), idle(-64));

    // asynchronous reset asserted between clock edges on LANES=2
    p_r = 1'b0; u_r = 1'b1; s_r = 1'b0; l_r = 1'b0; list_r = 16'h0FFF; vld2 = 1'b1;
    @(posedge clk); #1;
    vld2 = 1'b0;
    chk("async_pre", 0, get_obs(1), ob(1,1,2'b11, 0,0, 1,4, 0,0,0,0, 48));
    #2 rst = 1'b1;
    #1 chk("async_now", 0, get_obs(1), idle(0));
    @(posedge clk); #1;
    chk("async_edge", 0, get_obs(1), idle(0));
    rst = 1'b0; list_r = 16'h0003; vld2 = 1'b1;
    @(posedge clk); #1;
    vld2 = 1'b0;
    chk("async_after", 0, get_obs(1), ob(0,1,2'b11, 0,0, 1,4, 1,0,0,0, 8));
    @(posedge clk); #1;
    chk("async_idle", 0, get_obs(1), idle(8));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
